// File: rtl/fc_weight_fetcher.sv
// fc_weight_fetcher
//   Read-side master for the FC weight memory. A start pulse in IDLE begins a
//   pass that walks address_fc over 0..fc_columns-1. Each returned weight word
//   is captured into a 2-entry FIFO and offered to the FC PE array over a
//   valid/ready stream.
//
// Handshake: a word moves from the FIFO to the PE array on any rising clk edge
//   where weights_valid and weights_ready are both 1. weights_valid never drops
//   and weights_out/col_idx never change while a word waits for weights_ready.
//
// Ports
//   clk, reset           clock (posedge) and asynchronous active-high reset
//   start                begin a pass; only looked at in IDLE
//   address_fc           weight memory address (holds its value between reads)
//   read_en_MM_fc        1-cycle read strobe per issued address
//   enable_MM_out_fc     memory output enable, high in RUN and DRAIN
//   dataMainMemo_fc      word returned by the memory one cycle after a read
//   weights_out, col_idx head FIFO word and the address it was read from
//   weights_valid        FIFO not empty
//   weights_ready        PE array accepts the head word
//   busy, done           pass in progress / 1-cycle pulse at pass end
//   dbg_state            current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
module fc_weight_fetcher #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int parallel_fc_PE = 32,
  parameter int fc_columns     = 100
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic [ADDR_WIDTH-1:0]                address_fc,
  output logic                                 read_en_MM_fc,
  output logic                                 enable_MM_out_fc,
  input  logic [DATA_WIDTH*parallel_fc_PE-1:0] dataMainMemo_fc,
  output logic [DATA_WIDTH*parallel_fc_PE-1:0] weights_out,
  output logic [ADDR_WIDTH-1:0]                col_idx,
  output logic                                 weights_valid,
  input  logic                                 weights_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic [1:0]                           dbg_state
);

  localparam int WORD_W = DATA_WIDTH * parallel_fc_PE;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(fc_columns);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(fc_columns - 1);

  if (fc_columns < 1 || fc_columns > (2 ** ADDR_WIDTH)) begin : g_bad_cols
    $error("fc_columns must be in 1..2**ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      issue_cnt;
  logic [WORD_W-1:0]     buf_word [2];
  logic [ADDR_WIDTH-1:0] buf_col  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occupancy;
  logic [1:0]            count_next;

  // read_en_MM_fc doubles as the in-flight flag: the word for the address
  // issued last edge is on the bus now and is captured at the coming edge.
  // address_fc still holds that address, so it is the word's column.
  assign push          = read_en_MM_fc;
  assign pop           = weights_valid & weights_ready;
  assign weights_valid = (count != 2'd0);
  assign weights_out   = buf_word[rd_ptr];
  assign col_idx       = buf_col[rd_ptr];
  assign dbg_state     = state;

  // Slots committed after this edge; a new read only goes out if its word
  // is guaranteed a FIFO slot when it returns.
  assign occupancy  = 3'(count) + 3'(push) - 3'(pop);
  assign issue      = (state == RUN) && (issue_cnt < LAST) && (occupancy < 3'd2);
  assign count_next = count + 2'(push) - 2'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      issue_cnt        <= '0;
      address_fc       <= '0;
      read_en_MM_fc    <= 1'b0;
      enable_MM_out_fc <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      wr_ptr           <= 1'b0;
      rd_ptr           <= 1'b0;
      count            <= 2'd0;
      buf_word[0]      <= '0;
      buf_word[1]      <= '0;
      buf_col[0]       <= '0;
      buf_col[1]       <= '0;
    end else begin
      read_en_MM_fc <= 1'b0;
      done          <= 1'b0;

      if (push) begin
        buf_word[wr_ptr] <= dataMainMemo_fc;
        buf_col[wr_ptr]  <= address_fc;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;

      case (state)
        IDLE: begin
          if (start) begin
            address_fc       <= '0;
            read_en_MM_fc    <= 1'b1;
            enable_MM_out_fc <= 1'b1;
            busy             <= 1'b1;
            issue_cnt        <= CNT_W'(1);
            state            <= (fc_columns == 1) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            address_fc    <= issue_cnt[ADDR_WIDTH-1:0];
            read_en_MM_fc <= 1'b1;
            issue_cnt     <= issue_cnt + CNT_W'(1);
            if (issue_cnt == LAST_M1) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Nothing left to issue; an empty FIFO after this edge means the
          // last word has just been popped (an in-flight word would push).
          if (count_next == 2'd0) begin
            state            <= DONE;
            done             <= 1'b1;
            enable_MM_out_fc <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && count == 2'd2));

endmodule

// File: tb/tb_fc_weight_fetcher.sv
// Bench for fc_weight_fetcher: one instance with 100 columns driven through
// directed, stalled, random-ready and reset-mid-pass passes, checked against a
// queue-based model of the expected word stream, plus a 1-column instance for
// the single-word and start-while-busy corner.
module tb_fc_weight_fetcher;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int PE = 32;
  localparam int N  = 100;
  localparam int W  = DW * PE;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] address_fc;
  logic          read_en_MM_fc;
  logic          enable_MM_out_fc;
  logic [W-1:0]  mem_data;
  logic [W-1:0]  weights_out;
  logic [AW-1:0] col_idx;
  logic          weights_valid;
  logic          weights_ready;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  logic          start1;
  logic [AW-1:0] address1;
  logic          read_en1;
  logic          enable1;
  logic [W-1:0]  mem_data1;
  logic [W-1:0]  weights1;
  logic [AW-1:0] col1;
  logic          valid1;
  logic          ready1;
  logic          busy1;
  logic          done1;
  logic [1:0]    dbg_state1;

  always #5 clk = ~clk;

  fc_weight_fetcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .parallel_fc_PE(PE), .fc_columns(N)) dut (
    .clk(clk), .reset(reset), .start(start), .address_fc(address_fc),
    .read_en_MM_fc(read_en_MM_fc), .enable_MM_out_fc(enable_MM_out_fc),
    .dataMainMemo_fc(mem_data), .weights_out(weights_out), .col_idx(col_idx),
    .weights_valid(weights_valid), .weights_ready(weights_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  fc_weight_fetcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .parallel_fc_PE(PE), .fc_columns(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .address_fc(address1),
    .read_en_MM_fc(read_en1), .enable_MM_out_fc(enable1),
    .dataMainMemo_fc(mem_data1), .weights_out(weights1), .col_idx(col1),
    .weights_valid(valid1), .weights_ready(ready1),
    .busy(busy1), .done(done1), .dbg_state(dbg_state1)
  );

  // Every lane carries {address, lane+1}, so word 0 is distinguishable from reset zeros.
  function automatic logic [W-1:0] word_of(input int addr);
    logic [W-1:0] w;
    for (int i = 0; i < PE; i++) w[i*DW +: DW] = {16'(addr), 16'(i + 1)};
    return w;
  endfunction

  // Weight memory: samples address/read strobe on negedge, holds the word until the next negedge.
  always @(negedge clk) mem_data  <= read_en_MM_fc ? word_of(int'(address_fc)) : '0;
  always @(negedge clk) mem_data1 <= read_en1 ? word_of(int'(address1)) : '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act[255:0], exp[255:0]);
    end
  endtask

  // Reference model state: the words still owed to the PE array this pass.
  logic [W-1:0] exp_q[$];
  int           exp_col_q[$];
  int           exp_addr;
  bit           m_idle;
  bit           done_due;
  bit           last_pop;
  bit           prev_stall;
  logic [W-1:0] prev_word;
  logic [AW-1:0] prev_col;
  int ncyc, done_cnt;
  int pass_reads, pass_pops, pass_valid;
  int first_issue, last_issue, first_valid, last_valid;

  task automatic monitor();
    forever begin
      @(negedge clk);
      ncyc++;
      if (reset) begin
        exp_q.delete();
        exp_col_q.delete();
        exp_addr   = 0;
        m_idle     = 1'b1;
        done_due   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("done", done, done_due);
        chk("busy", busy, !m_idle);
        chk("enable", enable_MM_out_fc, !m_idle && !done_due);
        if (done) done_cnt++;
        if (read_en_MM_fc) begin
          chk("address", address_fc, exp_addr);
          exp_addr++;
          pass_reads++;
          if (first_issue < 0) first_issue = ncyc;
          last_issue = ncyc;
        end
        if (weights_valid) begin
          pass_valid++;
          if (first_valid < 0) first_valid = ncyc;
          last_valid = ncyc;
        end
        if (prev_stall) begin
          chk("hold_word", weights_out, prev_word);
          chk("hold_col", col_idx, prev_col);
        end
        last_pop = 1'b0;
        if (weights_valid && weights_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_pop: got col_idx %0d expected no word", col_idx);
          end else begin
            chk("word", weights_out, exp_q.pop_front());
            chk("col_idx", col_idx, exp_col_q.pop_front());
            pass_pops++;
            last_pop = (exp_q.size() == 0);
          end
        end
        prev_stall = weights_valid && !weights_ready;
        prev_word  = weights_out;
        prev_col   = col_idx;
        if (start && m_idle) begin
          for (int a = 0; a < N; a++) begin
            exp_q.push_back(word_of(a));
            exp_col_q.push_back(a);
          end
          exp_addr    = 0;
          pass_reads  = 0;
          pass_pops   = 0;
          pass_valid  = 0;
          first_issue = -1;
          first_valid = -1;
          m_idle      = 1'b0;
        end else if (done_due) begin
          m_idle = 1'b1;
        end
        done_due = last_pop;
      end
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd) weights_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got no done expected one within %0d cycles", budget);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_address"}, address_fc, 0);
    chk({tag, "_read_en"}, read_en_MM_fc, 0);
    chk({tag, "_enable"}, enable_MM_out_fc, 0);
    chk({tag, "_valid"}, weights_valid, 0);
    chk({tag, "_weights"}, weights_out, 0);
    chk({tag, "_col_idx"}, col_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  typedef struct {
    int   stall;      // cycles of weights_ready=0 right after the start edge
    int   exp_reads;  // reads issued inside that window
    logic exp_valid;  // weights_valid in the last stalled cycle
    int   exp_col;    // col_idx then, when valid
  } stall_vec_t;
  stall_vec_t tbl[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected one before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads, d0, n;
    logic v, re_last;
    logic [AW-1:0] c;
    logic [W-1:0] wv;

    tbl[0] = '{1, 1, 1'b0, 0};
    tbl[1] = '{2, 2, 1'b1, 0};
    tbl[2] = '{3, 2, 1'b1, 0};
    tbl[3] = '{10, 2, 1'b1, 0};

    reset = 1'b1; start = 1'b1; weights_ready = 1'b1;
    start1 = 1'b0; ready1 = 1'b1;
    m_idle = 1'b1;
    fork monitor(); join_none

    // Reset held with start high: everything stays zero, FSM stays IDLE.
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset");
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    chk("start_state", dbg_state, 1);
    chk("start_read_en", read_en_MM_fc, 1);
    chk("start_address", address_fc, 0);

    // Full-rate pass: 100 back-to-back reads and 100 back-to-back valid cycles.
    wait_done(400, 1'b0);
    chk("full_reads", pass_reads, N);
    chk("full_pops", pass_pops, N);
    chk("full_issue_span", last_issue - first_issue, N - 1);
    chk("full_valid_cycles", pass_valid, N);
    chk("full_valid_span", last_valid - first_valid, N - 1);
    chk("full_first_valid_lat", first_valid - first_issue, 1);

    // Back-pressure right after start.
    for (int r = 0; r < 4; r++) begin
      reads = 0; v = 1'b0; c = '0; wv = '0; re_last = 1'b0;
      weights_ready = 1'b0;
      do_start();
      for (int i = 0; i < tbl[r].stall; i++) begin
        @(negedge clk);
        if (read_en_MM_fc) reads++;
        if (i == tbl[r].stall - 1) begin
          v = weights_valid; c = col_idx; wv = weights_out; re_last = read_en_MM_fc;
        end
        @(posedge clk); #1;
      end
      weights_ready = 1'b1;
      chk($sformatf("stall%0d_reads", tbl[r].stall), reads, tbl[r].exp_reads);
      chk($sformatf("stall%0d_valid", tbl[r].stall), v, tbl[r].exp_valid);
      if (tbl[r].exp_valid) begin
        chk($sformatf("stall%0d_col", tbl[r].stall), c, tbl[r].exp_col);
        chk($sformatf("stall%0d_word", tbl[r].stall), wv, word_of(tbl[r].exp_col));
      end
      if (tbl[r].stall > 2) chk($sformatf("stall%0d_read_en", tbl[r].stall), re_last, 0);
      wait_done(400, 1'b0);
      chk($sformatf("stall%0d_pops", tbl[r].stall), pass_pops, N);
      chk($sformatf("stall%0d_pass_reads", tbl[r].stall), pass_reads, N);
    end

    // Random back-pressure, three passes.
    for (int p = 0; p < 3; p++) begin
      do_start();
      wait_done(1000, 1'b1);
      weights_ready = 1'b1;
      chk($sformatf("rand%0d_reads", p), pass_reads, N);
      chk($sformatf("rand%0d_pops", p), pass_pops, N);
    end

    // Reset in the middle of a pass.
    weights_ready = 1'b1;
    do_start();
    n = 0;
    while (pass_pops < 37 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (pass_pops < 37) begin
      checks++;
      errors++;
      $display("FAIL midreset_wait: got %0d pops expected 37", pass_pops);
    end
    #2 reset = 1'b1;
    #1 chk_zero("midreset");
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("midreset_no_done", done_cnt, d0);
    chk("midreset_idle_busy", busy, 0);
    do_start();
    chk("restart_address", address_fc, 0);
    chk("restart_read_en", read_en_MM_fc, 1);
    @(posedge clk); #1;
    chk("restart_valid", weights_valid, 1);
    chk("restart_col_idx", col_idx, 0);
    wait_done(400, 1'b0);
    chk("restart_pops", pass_pops, N);

    // Single-column instance, start held high through the whole pass.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("one_c0_read_en", read_en1, 1);
    chk("one_c0_address", address1, 0);
    chk("one_c0_state", dbg_state1, 2);
    chk("one_c0_enable", enable1, 1);
    chk("one_c0_valid", valid1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("one_c1_valid", valid1, 1);
    chk("one_c1_col", col1, 0);
    chk("one_c1_word", weights1, word_of(0));
    chk("one_c1_read_en", read_en1, 0);
    chk("one_c1_done", done1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("one_c2_done", done1, 1);
    chk("one_c2_valid", valid1, 0);
    chk("one_c2_busy", busy1, 1);
    chk("one_c2_state", dbg_state1, 3);
    chk("one_c2_enable", enable1, 0);
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk("one_c3_busy", busy1, 0);
    chk("one_c3_state", dbg_state1, 0);
    reads = 0; n = 0;
    repeat (4) begin
      @(negedge clk);
      if (read_en1) reads++;
      if (done1) n++;
    end
    chk("one_extra_reads", reads, 0);
    chk("one_extra_done", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
